// File: rtl/imm_split_encoder.sv
// rtl/imm_split_encoder.sv - narrows 8-bit constants into 5-bit SINGLE or HI/LO immediate beats
module imm_split_encoder #(
  parameter int DATA_W = 8,
  parameter int IMM_W  = 5,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] din,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IMM_W-1:0]  out_imm,
  output logic [1:0]        out_kind,
  output logic [CNT_W-1:0]  split_cnt,
  input  logic              clr_cnt
);

  localparam logic [1:0] KIND_SINGLE = 2'b00;
  localparam logic [1:0] KIND_HI     = 2'b01;
  localparam logic [1:0] KIND_LO     = 2'b10;

  // IDLE: nothing held, ONE: SINGLE held, HI: HI held with LO pending, LO: LO held
  typedef enum logic [1:0] {IDLE, ONE, HI, LO} state_t;

  state_t                state, state_d;
  logic [IMM_W-1:0]      imm_d;
  logic [1:0]            kind_d;
  logic [IMM_W-1:0]      lo_q, lo_d;
  logic [CNT_W-1:0]      cnt_d;
  logic                  accept;
  logic                  fits;
  logic [DATA_W-IMM_W:0] top_bits;
  logic [IMM_W-1:0]      hi_ext;

  // A constant fits one beat when everything from the immediate's sign bit upward is a sign copy
  assign top_bits = din[DATA_W-1:IMM_W-1];
  assign fits     = (&top_bits) | ~(|top_bits);

  // Upper part of a split constant, sign-extended to the immediate width
  assign hi_ext = IMM_W'($signed(din) >>> IMM_W);

  // HI must stay blocked so the pending LO beat always follows it
  assign in_ready  = (state == IDLE) || (((state == ONE) || (state == LO)) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state != IDLE);

  // Next state, next beat and next counter value; a fresh accept overrides the drain path
  always_comb begin
    state_d = state;
    imm_d   = out_imm;
    kind_d  = out_kind;
    lo_d    = lo_q;
    cnt_d   = split_cnt;

    case (state)
      HI: begin
        if (out_ready) begin
          state_d = LO;
          imm_d   = lo_q;
          kind_d  = KIND_LO;
        end
      end
      ONE, LO: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
      end
    endcase

    if (accept) begin
      if (fits) begin
        state_d = ONE;
        imm_d   = din[IMM_W-1:0];
        kind_d  = KIND_SINGLE;
      end else begin
        state_d = HI;
        imm_d   = hi_ext;
        kind_d  = KIND_HI;
        lo_d    = din[IMM_W-1:0];
        if (split_cnt != {CNT_W{1'b1}}) begin
          cnt_d = split_cnt + CNT_W'(1);
        end
      end
    end

    if (clr_cnt) begin
      cnt_d = '0;
    end
  end

  // State, held beat, pending LO part and split counter; reset drops any beat in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_imm   <= '0;
      out_kind  <= KIND_SINGLE;
      lo_q      <= '0;
      split_cnt <= '0;
    end else begin
      state     <= state_d;
      out_imm   <= imm_d;
      out_kind  <= kind_d;
      lo_q      <= lo_d;
      split_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_imm_split_encoder.sv
// tb/tb_imm_split_encoder.sv - self-checking bench for imm_split_encoder
module tb_imm_split_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] din = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [4:0] out_imm;
  logic [1:0] out_kind;
  logic [7:0] split_cnt;
  logic       clr_cnt = 1'b0;

  int checks = 0;
  int failures = 0;

  imm_split_encoder #(.DATA_W(8), .IMM_W(5), .CNT_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .din(din),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_imm(out_imm),
    .out_kind(out_kind),
    .split_cnt(split_cnt),
    .clr_cnt(clr_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    clr_cnt = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    din = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    checks++; if (out_imm !== 5'd0) begin failures++; $display("FAIL reset_imm: got %0h want 0", out_imm); end
    checks++; if (out_kind !== 2'b00) begin failures++; $display("FAIL reset_kind: got %0b want 00", out_kind); end
    checks++; if (split_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt: got %0d want 0", split_cnt); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_and_split();
    out_ready = 1'b1;
    send(8'h0F);
    checks++; if (out_valid !== 1'b1 || out_kind !== 2'b00 || out_imm !== 5'b01111) begin
      failures++; $display("FAIL single_0f: got v=%0b k=%0b imm=%b want v=1 k=00 imm=01111", out_valid, out_kind, out_imm); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_0f_idle: got %0b want 0", out_valid); end
    send(8'hF0);
    checks++; if (out_valid !== 1'b1 || out_kind !== 2'b00 || out_imm !== 5'b10000) begin
      failures++; $display("FAIL single_f0: got v=%0b k=%0b imm=%b want v=1 k=00 imm=10000", out_valid, out_kind, out_imm); end
    @(posedge clk); #1;
    send(8'h10);
    checks++; if (out_valid !== 1'b1 || out_kind !== 2'b01 || out_imm !== 5'b00000) begin
      failures++; $display("FAIL split_10_hi: got v=%0b k=%0b imm=%b want v=1 k=01 imm=00000", out_valid, out_kind, out_imm); end
    checks++; if (split_cnt !== 8'd1) begin failures++; $display("FAIL split_10_cnt: got %0d want 1", split_cnt); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_kind !== 2'b10 || out_imm !== 5'b10000) begin
      failures++; $display("FAIL split_10_lo: got v=%0b k=%0b imm=%b want v=1 k=10 imm=10000", out_valid, out_kind, out_imm); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL split_10_idle: got %0b want 0", out_valid); end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    send(8'hA5);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      din = 8'h01;
      #1;
      checks++; if (out_valid !== 1'b1 || out_kind !== 2'b01 || out_imm !== 5'b11101) begin
        failures++; $display("FAIL stall_hi_%0d: got v=%0b k=%0b imm=%b want v=1 k=01 imm=11101", i, out_valid, out_kind, out_imm); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready_%0d: got %0b want 0", i, in_ready); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_hi_ready: got %0b want 0", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_kind !== 2'b10 || out_imm !== 5'b00101) begin
      failures++; $display("FAIL stall_lo: got v=%0b k=%0b imm=%b want v=1 k=10 imm=00101", out_valid, out_kind, out_imm); end
    checks++; if (split_cnt !== 8'd2) begin failures++; $display("FAIL stall_cnt: got %0d want 2", split_cnt); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_idle: got %0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [3];
    vals[0] = 8'h01; vals[1] = 8'h02; vals[2] = 8'h03;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    din = vals[0];
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) din = vals[i+1];
      else in_valid = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b1 || out_kind !== 2'b00 || out_imm !== vals[i][4:0]) begin
        failures++; $display("FAIL b2b_beat_%0d: got v=%0b k=%0b imm=%b want v=1 k=00 imm=%b", i, out_valid, out_kind, out_imm, vals[i][4:0]); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_%0d: got %0b want 1", i, in_ready); end
      @(posedge clk); #1;
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle: got %0b want 0", out_valid); end
  endtask

  task automatic test_exhaustive();
    int         src_q [$];
    logic [4:0] imm_q [$];
    logic [1:0] kind_q [$];
    int         nxt = 0;
    int         cyc = 0;
    int         exp_cnt = 0;
    int         hi_seen = 0;
    int         recon, v, lo, hi, sx;
    logic       exp_rdy, acc;
    logic [4:0] o_imm, tmp5;
    logic [1:0] o_kind;
    pulse_reset();
    while ((nxt < 256 || imm_q.size() > 0) && cyc < 4000) begin
      in_valid = (nxt < 256) && ($urandom_range(0, 3) != 0);
      din = nxt[7:0];
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      exp_rdy = (imm_q.size() == 0) || (imm_q.size() == 1 && out_ready);
      checks++; if (in_ready !== exp_rdy) begin failures++; $display("FAIL exh_in_ready c%0d: got %0b want %0b", cyc, in_ready, exp_rdy); end
      checks++; if (out_valid !== (imm_q.size() > 0)) begin failures++; $display("FAIL exh_valid c%0d: got %0b want %0b", cyc, out_valid, imm_q.size() > 0); end
      o_imm = out_imm;
      o_kind = out_kind;
      if (imm_q.size() > 0) begin
        checks++; if (o_imm !== imm_q[0] || o_kind !== kind_q[0]) begin
          failures++; $display("FAIL exh_beat c%0d: got k=%0b imm=%b want k=%0b imm=%b", cyc, o_kind, o_imm, kind_q[0], imm_q[0]); end
      end
      acc = in_valid && exp_rdy;
      @(posedge clk);
      if (imm_q.size() > 0 && out_ready) begin
        void'(imm_q.pop_front());
        void'(kind_q.pop_front());
        sx = (o_imm >= 5'd16) ? int'(o_imm) - 32 : int'(o_imm);
        if (o_kind == 2'b01) begin
          hi_seen = sx;
        end else if (o_kind == 2'b00 || o_kind == 2'b10) begin
          recon = (o_kind == 2'b00) ? (sx & 255) : (((hi_seen * 32) | int'(o_imm)) & 255);
          checks++; if (recon != src_q[0]) begin failures++; $display("FAIL exh_recon: got %0h want %0h", recon, src_q[0]); end
          void'(src_q.pop_front());
        end else begin
          failures++; $display("FAIL exh_kind11: got %0b want not 11", o_kind);
        end
      end
      if (acc) begin
        v = (nxt >= 128) ? nxt - 256 : nxt;
        lo = nxt % 32;
        src_q.push_back(nxt);
        if (v >= -16 && v <= 15) begin
          tmp5 = lo[4:0];
          imm_q.push_back(tmp5); kind_q.push_back(2'b00);
        end else begin
          hi = (((v - lo) / 32) + 32) % 32;
          tmp5 = hi[4:0];
          imm_q.push_back(tmp5); kind_q.push_back(2'b01);
          tmp5 = lo[4:0];
          imm_q.push_back(tmp5); kind_q.push_back(2'b10);
          exp_cnt++;
        end
        nxt++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (cyc >= 4000) begin failures++; $display("FAIL exh_timeout: got %0d inputs sent want 256", nxt); end
    #1;
    checks++; if (int'(split_cnt) != exp_cnt || split_cnt !== 8'd224) begin
      failures++; $display("FAIL exh_cnt: got %0d want 224 (model %0d)", split_cnt, exp_cnt); end
  endtask

  task automatic test_saturate();
    out_ready = 1'b1;
    for (int i = 0; i < 31; i++) begin
      send(8'h40);
      @(posedge clk);
    end
    #1;
    checks++; if (split_cnt !== 8'd255) begin failures++; $display("FAIL sat_reach: got %0d want 255", split_cnt); end
    send(8'h40);
    checks++; if (split_cnt !== 8'd255) begin failures++; $display("FAIL sat_hold: got %0d want 255", split_cnt); end
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_clr();
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    din = 8'h80;
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    clr_cnt = 1'b0;
    checks++; if (split_cnt !== 8'd0) begin failures++; $display("FAIL clr_cnt: got %0d want 0", split_cnt); end
    checks++; if (out_kind !== 2'b01 || out_imm !== 5'b11100) begin
      failures++; $display("FAIL clr_hi: got k=%0b imm=%b want k=01 imm=11100", out_kind, out_imm); end
    @(posedge clk); #1;
    checks++; if (out_kind !== 2'b10 || out_imm !== 5'b00000) begin
      failures++; $display("FAIL clr_lo: got k=%0b imm=%b want k=10 imm=00000", out_kind, out_imm); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_split();
    out_ready = 1'b0;
    send(8'h80);
    checks++; if (out_valid !== 1'b1 || out_kind !== 2'b01 || split_cnt !== 8'd1) begin
      failures++; $display("FAIL rst_pre: got v=%0b k=%0b cnt=%0d want v=1 k=01 cnt=1", out_valid, out_kind, split_cnt); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || split_cnt !== 8'd0) begin
      failures++; $display("FAIL rst_async: got v=%0b cnt=%0d want v=0 cnt=0", out_valid, split_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_no_lo_%0d: got %0b want 0", i, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_single_and_split();
    test_stall();
    test_back_to_back();
    test_exhaustive();
    test_saturate();
    test_clr();
    test_reset_mid_split();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
